mem_stage_pipe: RTL
===================

# mem_stage_pipe

Parametrised memory stage for the pipelined processor. It selects the data-memory address and store data, accesses an internal data memory with a configurable load latency, stalls upstream while a load waits, and registers the results into the M/WB pipeline latch. It supersedes the fixed 8-bit, single-cycle memory stage. It adds data-width and depth parameters, multi-cycle loads with a stall handshake, flush, valid tracking and a sticky error flag.

## Interface
Parameters:
- DATA_W, 8, datapath and memory word width (≥8)
- DEPTH, 256, data memory words; ADDR_W = $clog2(DEPTH)
- MEM_LAT, 1, load occupancy in cycles (1..8); stores always take 1 cycle
- REG_AW, 2, register-file address width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- valid_M  in  1  instruction in M is real
- flush_M  in  1  kill the instruction in M
- D_mem_wenM, D_mem_renM  in  1  store / load request
- mux8sM  in  3  address select
- mux9sM  in  2  store-data select
- sub_outM, data_out1M, data_out2M, ALU_resultM, Imm_EX, pcM, instrM  in  DATA_W  EX-stage values
- dest_addrM  in  REG_AW  destination register
- reg_file_wenM  in  2  register write enables
- mux10sM  in  3  WB mux select
- sp_mux_sM, RET_enM  in  1  stack/return controls
- stall_M  out  1  hold IF..EX and the M inputs this cycle (combinational)
- data_mem_outM  out  DATA_W  combinational read data, for forwarding
- valid_WB  out  1  WB latch holds a real instruction
- dest_addrWB, reg_file_wenWB, mux10_sWB, sp_mux_sWB, RET_enWB, ALU_resultWB, data_mem_outWB, sub_outWB, instrWB  out  registered copies, same widths as the M inputs
- err  out  1  sticky illegal-access flag

## Operation
- Address mux (mux8sM): 0 sub_outM, 1 data_out2M, 2 data_out1M, 3 ALU_resultM, 4 Imm_EX, 5 {RET_enWB, zeros}, 6–7 zero. The memory index is the low ADDR_W bits of the result, so addresses wrap modulo DEPTH.
- Store-data mux (mux9sM): 0 ALU_resultM, 1 data_out1M, 2 pcM, 3 zero.
- Memory: DEPTH×DATA_W array, asynchronous read, synchronous write. It is not cleared by rst.
- A request is active when valid_M=1 and flush_M=0.
- Store: active and wen=1. The array is written at the end of the cycle. No stall.
- Load: active, ren=1, wen=0. The stage moves through FSM states IDLE → WAIT → IDLE.
  - cnt counts 0..MEM_LAT-1.
  - stall_M = load active and cnt ≠ MEM_LAT-1.
  - While stalled, cnt increments and the WB latch takes a bubble: valid_WB=0, reg_file_wenWB=0, RET_enWB=0, other fields hold.
  - On the final cycle, data_mem_outM is captured into data_mem_outWB, cnt returns to 0, and the FSM goes to IDLE.
- ren=1 and wen=1 together: treated as a store, the load is ignored, and err is set. err clears only on rst.
- Non-memory active instruction: passes to WB in 1 cycle.
- Inactive cycle (valid_M=0 or flush_M=1): bubble into WB, no write, cnt←0, FSM→IDLE, stall_M=0. This includes a flush in the middle of a WAIT, which aborts the load.
- Upstream must hold all M inputs stable while stall_M=1. Input changes during a stall are not supported.

## Timing
- Reset (synchronous rst=1 sampled on a rising edge):
  - all WB outputs 0, valid_WB=0, err=0, cnt=0, FSM=IDLE
  - stall_M=0 in the cycle rst is high
  - no memory write that cycle
- Latency from M to WB: 1 cycle for stores and ALU ops; MEM_LAT cycles for loads.
- Stall duration: stall_M is high for exactly MEM_LAT-1 consecutive cycles per load. With MEM_LAT=1, loads never stall.
- Back-to-back loads: each restarts at cnt=0 and has no extra bubble.
- Store then load to the same address in consecutive cycles: the load reads the newly stored value.
- RET_enWB in address slot 5 is the registered WB value, i.e. the previous instruction's.

## Test plan
- Reset with rst=1 for one clock: all WB outputs 0, valid_WB=0, err=0, stall_M=0.
- DATA_W=8, MEM_LAT=1:
  - store ALU_result=0x5A to Imm_EX=0x10 (mux8s=4, mux9s=0), then load from 0x10 next cycle → data_mem_outWB=0x5A, valid_WB=1, stall_M never high.
- MEM_LAT=3, load from 0x20 (holding 0x33):
  - stall_M high for 2 cycles with valid_WB=0 in each
  - third cycle: data_mem_outWB=0x33, valid_WB=1.
- MEM_LAT=3, flush_M raised on the second stall cycle of a load: stall_M drops immediately, valid_WB=0, and the next load stalls the full 2 cycles again.
- DEPTH=16, store 0xAB to address 0x13: a load from 0x03 returns 0xAB (wrap-around).
- ren=1 and wen=1 together with data 0x77 at address 4:
  - memory[4]=0x77 and err=1
  - err stays 1 across later instructions until rst.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe
// Memory stage of the pipelined processor: selects the data-memory address
// and store data, accesses an internal data memory with a configurable load
// occupancy, stalls upstream while a load is outstanding, and registers the
// results into the M/WB pipeline latch. Carries a WB valid bit and a sticky
// flag for the illegal simultaneous load+store request.

module mem_stage_pipe #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1,
    parameter int REG_AW  = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    // M-stage control
    input  logic              valid_M,
    input  logic              flush_M,
    input  logic              D_mem_wenM,
    input  logic              D_mem_renM,
    input  logic [2:0]        mux8sM,
    input  logic [1:0]        mux9sM,

    // M-stage data carried from EX
    input  logic [DATA_W-1:0] sub_outM,
    input  logic [DATA_W-1:0] data_out1M,
    input  logic [DATA_W-1:0] data_out2M,
    input  logic [DATA_W-1:0] ALU_resultM,
    input  logic [DATA_W-1:0] Imm_EX,
    input  logic [DATA_W-1:0] pcM,
    input  logic [DATA_W-1:0] instrM,

    // Write-back controls passed through the stage
    input  logic [REG_AW-1:0] dest_addrM,
    input  logic [1:0]        reg_file_wenM,
    input  logic [2:0]        mux10sM,
    input  logic              sp_mux_sM,
    input  logic              RET_enM,

    // Hazard / forwarding
    output logic              stall_M,
    output logic [DATA_W-1:0] data_mem_outM,

    // M/WB latch
    output logic              valid_WB,
    output logic [REG_AW-1:0] dest_addrWB,
    output logic [1:0]        reg_file_wenWB,
    output logic [2:0]        mux10_sWB,
    output logic              sp_mux_sWB,
    output logic              RET_enWB,
    output logic [DATA_W-1:0] ALU_resultWB,
    output logic [DATA_W-1:0] data_mem_outWB,
    output logic [DATA_W-1:0] sub_outWB,
    output logic [DATA_W-1:0] instrWB,

    output logic              err
);

    // Load-occupancy counter width; at least one bit so MEM_LAT=1 still elaborates.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    // Elaboration-time guards on the parameter space this stage supports.
    if (DATA_W < 8) begin : g_chk_data_w
        $error("mem_stage_pipe: DATA_W must be at least 8");
    end
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_chk_mem_lat
        $error("mem_stage_pipe: MEM_LAT must be in 1..8");
    end
    if (ADDR_W > DATA_W || DEPTH != (1 << ADDR_W)) begin : g_chk_depth
        $error("mem_stage_pipe: DEPTH must be a power of two addressable by DATA_W bits");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_valid_wb;
    logic [REG_AW-1:0] r_dest_addr_wb;
    logic [1:0]        r_reg_file_wen_wb;
    logic [2:0]        r_mux10_s_wb;
    logic              r_sp_mux_s_wb;
    logic              r_ret_en_wb;
    logic [DATA_W-1:0] r_alu_result_wb;
    logic [DATA_W-1:0] r_data_mem_out_wb;
    logic [DATA_W-1:0] r_sub_out_wb;
    logic [DATA_W-1:0] r_instr_wb;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic              w_active;
    logic              w_store;
    logic              w_load;
    logic              w_both;
    logic              w_last;
    logic              w_stall;
    logic              w_advance;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [CNT_W-1:0]  w_cnt_next;

    assign w_active = valid_M & ~flush_M;
    // A simultaneous load+store is carried out as a store only.
    assign w_store  = w_active & D_mem_wenM;
    assign w_load   = w_active & D_mem_renM & ~D_mem_wenM;
    assign w_both   = w_active & D_mem_renM & D_mem_wenM;

    // The final occupancy cycle of a load is the one that releases the stall.
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_stall  = ~rst & w_load & ~w_last;

    // The instruction leaves M this cycle and lands in the WB latch.
    assign w_advance = w_active & ~w_stall;

    // A fresh load starts counting from zero even if cnt was left non-zero.
    assign w_cnt_next = ((r_state == ST_WAIT) ? r_cnt : '0) + CNT_W'(1);

    // Address select; only the low ADDR_W bits index memory, so addresses wrap.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no path can infer a latch.
        w_addr = '0;
        unique case (mux8sM)
            3'd0:    w_addr = ADDR_W'(sub_outM);
            3'd1:    w_addr = ADDR_W'(data_out2M);
            3'd2:    w_addr = ADDR_W'(data_out1M);
            3'd3:    w_addr = ADDR_W'(ALU_resultM);
            3'd4:    w_addr = ADDR_W'(Imm_EX);
            3'd5:    w_addr = ADDR_W'({r_ret_en_wb, {(DATA_W-1){1'b0}}});
            default: w_addr = '0;
        endcase
    end

    // Store-data select.
    always_comb begin
        w_wdata = '0;
        unique case (mux9sM)
            2'd0:    w_wdata = ALU_resultM;
            2'd1:    w_wdata = data_out1M;
            2'd2:    w_wdata = pcM;
            default: w_wdata = '0;
        endcase
    end

    // Asynchronous read port; a store in the previous cycle is already visible.
    assign w_rdata = r_mem[w_addr];

    // ------------------------------------------------------------------
    // Data memory write port
    // ------------------------------------------------------------------
    // Store into the array at the end of the cycle; suppressed while in reset.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; clearing it would cost a write per word and software never relies on it.
        if (!rst && w_store) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Load-occupancy FSM and sticky error flag
    // ------------------------------------------------------------------
    // Track how long an active load has been waiting and latch illegal requests.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_both) begin
                r_err <= 1'b1;
            end
            if (w_stall) begin
                r_state <= ST_WAIT;
                r_cnt   <= w_cnt_next;
            end else begin
                // Final load cycle, non-load instruction, bubble or flush.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // M/WB pipeline latch
    // ------------------------------------------------------------------
    // Capture the instruction when it leaves M, otherwise insert a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_wb        <= 1'b0;
            r_dest_addr_wb    <= '0;
            r_reg_file_wen_wb <= '0;
            r_mux10_s_wb      <= '0;
            r_sp_mux_s_wb     <= 1'b0;
            r_ret_en_wb       <= 1'b0;
            r_alu_result_wb   <= '0;
            r_data_mem_out_wb <= '0;
            r_sub_out_wb      <= '0;
            r_instr_wb        <= '0;
        end else if (w_advance) begin
            r_valid_wb        <= 1'b1;
            r_dest_addr_wb    <= dest_addrM;
            r_reg_file_wen_wb <= reg_file_wenM;
            r_mux10_s_wb      <= mux10sM;
            r_sp_mux_s_wb     <= sp_mux_sM;
            r_ret_en_wb       <= RET_enM;
            r_alu_result_wb   <= ALU_resultM;
            r_data_mem_out_wb <= w_rdata;
            r_sub_out_wb      <= sub_outM;
            r_instr_wb        <= instrM;
        end else begin
            // Bubble: kill every side effect in WB, let the data fields hold.
            r_valid_wb        <= 1'b0;
            r_reg_file_wen_wb <= '0;
            r_ret_en_wb       <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_M        = w_stall;
    assign data_mem_outM  = w_rdata;
    assign valid_WB       = r_valid_wb;
    assign dest_addrWB    = r_dest_addr_wb;
    assign reg_file_wenWB = r_reg_file_wen_wb;
    assign mux10_sWB      = r_mux10_s_wb;
    assign sp_mux_sWB     = r_sp_mux_s_wb;
    assign RET_enWB       = r_ret_en_wb;
    assign ALU_resultWB   = r_alu_result_wb;
    assign data_mem_outWB = r_data_mem_out_wb;
    assign sub_outWB      = r_sub_out_wb;
    assign instrWB        = r_instr_wb;
    assign err            = r_err;

endmodule
